// File: rtl/ext_mem_burst_responder.sv
// ext_mem_burst_responder: on-chip word array answering external-memory burst commands
module ext_mem_burst_responder #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_LOG2  = 12,
    parameter int STALL_EVERY = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ext_mem_burst,
    input  logic [4:0]        ext_mem_burst_len_minus1,
    input  logic [ADDR_W-1:0] ext_mem_addr,
    input  logic              ext_mem_wr,
    input  logic [DATA_W-1:0] ext_mem_d,
    input  logic              ext_mem_rd,
    output logic [DATA_W-1:0] ext_mem_q,
    output logic              ext_mem_valid,
    output logic              ext_mem_full,
    output logic              ext_mem_init_done,
    output logic              protocol_err
);
    typedef enum logic [2:0] {INIT, IDLE, ARMED, WRITE, READ} state_t;
    localparam int AW = DEPTH_LOG2;

    state_t            state_q, state_d;
    logic [AW-1:0]     base_q, base_d, init_idx_q, init_idx_d;
    logic [4:0]        len_q, len_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;
    logic              full_q, full_d, init_done_q, init_done_d;
    logic              perr_q, perr_d, pend_q, pend_d, valid_q, valid_d;
    logic [DATA_W-1:0] q_q, q_d, rdata_q, wdata;
    logic [AW-1:0]     in_base, cur_base, widx, ridx;
    logic [4:0]        cur_len;
    logic              we, accept, stall_hit, wr_ok, rd_ok, armed;
    logic [DATA_W-1:0] mem [0:(1<<AW)-1];
    logic              unused_addr;

    assign unused_addr = ^{ext_mem_addr[ADDR_W-1:AW+2], ext_mem_addr[1:0]};
    assign in_base     = ext_mem_addr[AW+1:2];
    // A burst in IDLE may carry its first beat or read start in the same cycle
    assign cur_base    = state_q == IDLE ? in_base : base_q;
    assign cur_len     = state_q == IDLE ? ext_mem_burst_len_minus1 : len_q;
    assign wr_ok       = ext_mem_wr && !full_q;
    assign rd_ok       = ext_mem_rd && !ext_mem_wr && !full_q;
    assign armed       = (state_q == IDLE && ext_mem_burst) || state_q == ARMED;
    assign ridx        = base_q + AW'(cnt_q);

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        init_idx_d  = init_idx_q;
        init_done_d = init_done_q;
        perr_d      = perr_q;
        pend_d      = 1'b0;
        we          = 1'b0;
        accept      = 1'b0;
        widx        = cur_base + AW'(cnt_q);
        wdata       = ext_mem_d;
        case (state_q)
            INIT: begin
                we         = 1'b1;
                widx       = init_idx_q;
                wdata      = '0;
                init_idx_d = init_idx_q + 1'b1;
                if (&init_idx_q) begin
                    state_d     = IDLE;
                    init_done_d = 1'b1;
                end
            end
            IDLE: begin
                if (ext_mem_burst) begin
                    state_d = ARMED;
                    base_d  = in_base;
                    len_d   = ext_mem_burst_len_minus1;
                    cnt_d   = '0;
                end else if (ext_mem_wr || ext_mem_rd) begin
                    perr_d = 1'b1;
                end
            end
            WRITE: begin
                if (wr_ok) begin
                    we     = 1'b1;
                    accept = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == {1'b0, len_q}) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            // cnt_q counts issued array reads; one extra cycle drains the output stage
            READ: begin
                if (cnt_q <= {1'b0, len_q}) begin
                    pend_d = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: ;
        endcase
        if (armed) begin
            if (ext_mem_wr && ext_mem_rd) perr_d = 1'b1;
            if (wr_ok) begin
                we      = 1'b1;
                accept  = 1'b1;
                state_d = cur_len == 5'd0 ? IDLE : WRITE;
                cnt_d   = cur_len == 5'd0 ? 6'd0 : 6'd1;
            end else if (rd_ok) begin
                state_d = READ;
                cnt_d   = '0;
            end
        end
        if (ext_mem_burst && (state_q == ARMED || state_q == WRITE || state_q == READ)) perr_d = 1'b1;
        stall_hit   = STALL_EVERY > 0 && accept && stall_cnt_q == 16'(STALL_EVERY - 1);
        stall_cnt_d = accept ? (stall_hit ? '0 : stall_cnt_q + 1'b1) : stall_cnt_q;
        full_d      = state_d == INIT || state_d == READ || state_q == READ || stall_hit;
        valid_d     = pend_q;
        q_d         = pend_q ? rdata_q : q_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT;
            base_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            init_idx_q  <= '0;
            init_done_q <= 1'b0;
            perr_q      <= 1'b0;
            pend_q      <= 1'b0;
            valid_q     <= 1'b0;
            q_q         <= '0;
            full_q      <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            init_idx_q  <= init_idx_d;
            init_done_q <= init_done_d;
            perr_q      <= perr_d;
            pend_q      <= pend_d;
            valid_q     <= valid_d;
            q_q         <= q_d;
            full_q      <= full_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we && !rst) mem[widx] <= wdata;
        rdata_q <= mem[ridx];
    end

    assign ext_mem_q         = q_q;
    assign ext_mem_valid     = valid_q;
    assign ext_mem_full      = full_q;
    assign ext_mem_init_done = init_done_q;
    assign protocol_err      = perr_q;
endmodule

// File: tb/tb_ext_mem_burst_responder.sv
// tb_ext_mem_burst_responder: randomized scoreboard bench for ext_mem_burst_responder
module tb_ext_mem_burst_responder;
    localparam int DL    = 4;
    localparam int DEPTH = 1 << DL;
    localparam int SE    = 2;

    logic        clk = 1'b0, rst = 1'b1, burst = 1'b0, wr = 1'b0, rd = 1'b0;
    logic [4:0]  lenm1 = '0;
    logic [31:0] addr = '0, d = '0;
    logic [31:0] q;
    logic        valid, full, init_done, perr;

    int          checks = 0, errors = 0, beats = 0;
    logic        exp_perr = 1'b0;
    logic [31:0] model [DEPTH];
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    ext_mem_burst_responder #(
        .ADDR_W(32), .DATA_W(32), .DEPTH_LOG2(DL), .STALL_EVERY(SE)
    ) dut (
        .clk(clk), .rst(rst),
        .ext_mem_burst(burst), .ext_mem_burst_len_minus1(lenm1), .ext_mem_addr(addr),
        .ext_mem_wr(wr), .ext_mem_d(d), .ext_mem_rd(rd),
        .ext_mem_q(q), .ext_mem_valid(valid), .ext_mem_full(full),
        .ext_mem_init_done(init_done), .protocol_err(perr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every valid beat must match the oldest expected word
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid q=%0h required no valid", q);
            end else begin
                chk("read_data", q, exp_q.pop_front());
            end
        end
    end

    function automatic int word_idx(input logic [31:0] a, input int k);
        return int'(((a >> 2) + 32'(k)) % DEPTH);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; burst = 1'b0; wr = 1'b0; rd = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_full", 32'(full), 1);
        chk("rst_init_done", 32'(init_done), 0);
        chk("rst_perr", 32'(perr), 0);
        chk("rst_q", q, 0);
        rst = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            @(negedge clk);
            chk("init_full", 32'(full), 1);
            chk("init_done_low", 32'(init_done), 0);
        end
        @(negedge clk);
        chk("init_done_rise", 32'(init_done), 1);
        chk("init_full_drop", 32'(full), 0);
        exp_q.delete();
        beats = 0;
        exp_perr = 1'b0;
        foreach (model[i]) model[i] = '0;
    endtask

    task automatic do_write(input logic [31:0] a, input int len, input bit coinc, input logic [31:0] seq);
        logic [31:0] wd [32];
        int k = 0, guard = 0;
        bit ef = 1'b0;
        foreach (wd[i]) wd[i] = seq != 0 ? seq + 32'(i) : $urandom;
        @(negedge clk);
        burst = 1'b1; addr = a; lenm1 = 5'(len); wr = coinc; d = wd[0];
        if (!coinc) begin
            @(negedge clk);
            burst = 1'b0; wr = 1'b1;
        end
        while (k <= len && guard < 200) begin
            @(negedge clk);
            burst = 1'b0;
            guard++;
            if (!ef) begin
                model[word_idx(a, k)] = wd[k];
                k++;
                beats++;
                ef = (beats % SE == 0);
            end else begin
                ef = 1'b0;
            end
            chk("wr_full", 32'(full), 32'(ef));
            if (k <= len) d = wd[k];
            else wr = 1'b0;
        end
        if (k <= len) begin
            checks++;
            errors++;
            wr = 1'b0;
            $display("FAIL write_timeout beats=%0d required=%0d", k, len + 1);
        end
        @(negedge clk);
        chk("wr_end_full", 32'(full), 0);
        chk("wr_perr", 32'(perr), 32'(exp_perr));
    endtask

    task automatic do_read(input logic [31:0] a, input int len, input bit coinc, input bit inject);
        logic [31:0] last;
        @(negedge clk);
        burst = 1'b1; addr = a; lenm1 = 5'(len); rd = coinc;
        if (!coinc) begin
            @(negedge clk);
            burst = 1'b0; rd = 1'b1;
        end
        for (int k = 0; k <= len; k++) exp_q.push_back(model[word_idx(a, k)]);
        last = model[word_idx(a, len)];
        @(negedge clk);
        burst = 1'b0; rd = 1'b0;
        chk("rd_full_after_accept", 32'(full), 1);
        chk("rd_lat0", 32'(valid), 0);
        @(negedge clk);
        chk("rd_lat1", 32'(valid), 0);
        for (int k = 0; k <= len; k++) begin
            @(negedge clk);
            chk("rd_valid", 32'(valid), 1);
            chk("rd_full", 32'(full), 1);
            if (inject && k == 0) begin
                burst = 1'b1; addr = $urandom; lenm1 = 5'($urandom); exp_perr = 1'b1;
            end else begin
                burst = 1'b0;
            end
        end
        burst = 1'b0;
        @(negedge clk);
        chk("rd_valid_end", 32'(valid), 0);
        chk("rd_q_hold", q, last);
        chk("rd_drained", 32'(exp_q.size()), 0);
        @(negedge clk);
        chk("rd_full_end", 32'(full), 0);
        chk("rd_perr", 32'(perr), 32'(exp_perr));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int len;
        do_reset();
        do_read(32'h0, 15, 1'b0, 1'b0);
        do_write(32'h40, 3, 1'b0, 32'hA0);
        do_read(32'h40, 3, 1'b0, 1'b0);
        do_reset();
        do_write(32'h10, 5, 1'b0, 32'h100);
        do_read(32'h10, 5, 1'b1, 1'b0);
        do_write(32'h38, 3, 1'b1, 32'h1);
        do_read(32'h38, 3, 1'b0, 1'b0);
        do_read(32'h0, 1, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            len = $urandom_range(0, 7) == 0 ? 31 : int'($urandom_range(0, 9));
            if ($urandom_range(0, 1) == 0) do_write(a, len, 1'($urandom), 32'h0);
            else do_read(a, len, 1'($urandom), 1'b0);
        end
        // stray read start without a burst command
        @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        exp_perr = 1'b1;
        chk("perr_stray_rd", 32'(perr), 1);
        @(negedge clk);
        chk("stray_rd_no_valid", 32'(valid), 0);
        do_read(32'h8, 5, 1'b0, 1'b1);
        do_write(32'h20, 2, 1'b0, 32'h0);
        do_read(32'h20, 2, 1'b1, 1'b0);
        // reset while a read burst is in flight
        a = 32'h0;
        @(negedge clk);
        burst = 1'b1; addr = a; lenm1 = 5'd7; rd = 1'b1;
        for (int k = 0; k < 8; k++) exp_q.push_back(model[word_idx(a, k)]);
        @(negedge clk);
        burst = 1'b0; rd = 1'b0;
        @(negedge clk);
        @(negedge clk);
        do_reset();
        do_read(32'h0, 15, 1'b0, 1'b0);
        chk("perr_after_reset", 32'(perr), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
